seg7_scan_scheduler: RTL

//   Time-multiplexes NUM_DIGITS hex digits onto one shared 7-segment bus plus one-hot digit enables.

---
 rtl/seg7_scan_scheduler_if.sv | 13 +
 rtl/seg7_scan_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_scheduler_if.sv
// Display-word handshake between the value formatter (master) and the
// 7-segment scan scheduler (slave).
interface seg7_scan_scheduler_if #(
   parameter int NUM_DIGITS = 6
);
   logic [4*NUM_DIGITS-1:0] value_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    value_valid;
   logic                    value_ready;

   modport master (output value_in, output dp_in, output value_valid, input value_ready);
   modport slave  (input value_in, input dp_in, input value_valid, output value_ready);
endinterface

// File: rtl/seg7_scan_scheduler.sv
// 7-segment scan scheduler: time-multiplexes NUM_DIGITS hex digits onto one
// segment bus with a blanking gap before every drive slot. New words are
// staged through a valid/ready handshake and swapped in at frame start only.
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero suppression.
// Outputs are registered from the next-state values, so they change on the
// same edge as the FSM state they reflect.
module seg7_scan_scheduler #(
   parameter int NUM_DIGITS   = 6,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter bit SEG_ACT_LOW  = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        enable,
   seg7_scan_scheduler_if.slave        vin,
   output logic [NUM_DIGITS-1:0]       digit_sel,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic                        frame_done
);
   localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DWELL_CYCLES - BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]       SEG_POL    = {7{SEG_ACT_LOW}};

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

   // Active-high {g,f,e,d,c,b,a} patterns for 0-F
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      case (nib)
         4'h0: hex_decode = 7'h3F;  4'h1: hex_decode = 7'h06;
         4'h2: hex_decode = 7'h5B;  4'h3: hex_decode = 7'h4F;
         4'h4: hex_decode = 7'h66;  4'h5: hex_decode = 7'h6D;
         4'h6: hex_decode = 7'h7D;  4'h7: hex_decode = 7'h07;
         4'h8: hex_decode = 7'h7F;  4'h9: hex_decode = 7'h6F;
         4'hA: hex_decode = 7'h77;  4'hB: hex_decode = 7'h7C;
         4'hC: hex_decode = 7'h39;  4'hD: hex_decode = 7'h5E;
         4'hE: hex_decode = 7'h79;  default: hex_decode = 7'h71;
      endcase
   endfunction

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d, act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
   logic                    pend_q, pend_d;
   logic                    value_ready_q, value_ready_d;
   logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    frame_done_q, frame_done_d;
   logic                    xfer, swap;
`ifdef SEG7_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0]   show_q, show_d;
`endif

   // Scan FSM: IDLE -> BLANK -> DRIVE -> BLANK ..., prescaler reloads on every transition
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (enable) state_d = S_BLANK;
         end
         S_BLANK: begin
            if (!enable) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == BLANK_LAST) begin
               state_d = S_DRIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DRIVE: begin
            if (!enable) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == DRIVE_LAST) begin
               state_d = S_BLANK;
               cnt_d   = '0;
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Staging/active registers; the swap happens in the first BLANK cycle of digit 0
   always_comb begin
      xfer      = vin.value_valid & value_ready_q;
      swap      = (state_q == S_BLANK) && (idx_q == '0) && (cnt_q == '0);
      stg_val_d = stg_val_q;
      stg_dp_d  = stg_dp_q;
      act_val_d = act_val_q;
      act_dp_d  = act_dp_q;
      pend_d    = pend_q;
      if (swap) begin
         act_val_d = stg_val_q;
         act_dp_d  = stg_dp_q;
         pend_d    = 1'b0;
      end
      // A transfer landing on the swap cycle goes to staging for the next frame
      if (xfer) begin
         stg_val_d = vin.value_in;
         stg_dp_d  = vin.dp_in;
         pend_d    = 1'b1;
      end
      value_ready_d = ~pend_d;
   end

`ifdef SEG7_LZ_BLANK_EN
   // Leading-zero mask, frozen at the swap: digit 0 always shows
   always_comb begin
      logic seen;
      show_d = show_q;
      seen   = 1'b0;
      if (swap) begin
         for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen      = seen | (|act_val_d[4*i +: 4]);
            show_d[i] = seen | (i == 0);
         end
      end
   end
`endif

   // Output decode from next state, so outputs are registered alongside the FSM
   always_comb begin
      logic [3:0] nib;
      logic       dpb;
      logic [6:0] pat;
      logic       lit;
      digit_sel_d = '0;
      nib         = '0;
      dpb         = 1'b0;
      lit         = 1'b1;
      if (state_d == S_DRIVE) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
               digit_sel_d[i] = 1'b1;
               nib            = act_val_d[4*i +: 4];
               dpb            = act_dp_d[i];
`ifdef SEG7_LZ_BLANK_EN
               lit            = show_d[i];
`endif
            end
         end
      end else begin
         lit = 1'b0;
      end
      pat          = lit ? hex_decode(nib) : 7'h00;
      seg_d        = pat ^ SEG_POL;
      dp_d         = dpb ^ SEG_ACT_LOW;
      frame_done_d = (state_d == S_DRIVE) && (idx_d == IDX_LAST) && (cnt_d == DRIVE_LAST);
   end

   // State and output registers, all cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         idx_q         <= '0;
         stg_val_q     <= '0;
         stg_dp_q      <= '0;
         act_val_q     <= '0;
         act_dp_q      <= '0;
         pend_q        <= 1'b0;
         value_ready_q <= 1'b1;
         digit_sel_q   <= '0;
         seg_q         <= SEG_POL;
         dp_q          <= SEG_ACT_LOW;
         frame_done_q  <= 1'b0;
`ifdef SEG7_LZ_BLANK_EN
         show_q        <= NUM_DIGITS'(1);
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         stg_val_q     <= stg_val_d;
         stg_dp_q      <= stg_dp_d;
         act_val_q     <= act_val_d;
         act_dp_q      <= act_dp_d;
         pend_q        <= pend_d;
         value_ready_q <= value_ready_d;
         digit_sel_q   <= digit_sel_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         frame_done_q  <= frame_done_d;
`ifdef SEG7_LZ_BLANK_EN
         show_q        <= show_d;
`endif
      end
   end

   assign vin.value_ready = value_ready_q;
   assign digit_sel       = digit_sel_q;
   assign seg             = seg_q;
   assign dp              = dp_q;
   assign frame_done      = frame_done_q;
endmodule
